// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - opcodes, queue entry type and immediate decoders shared by the fetch stage
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] inst;
    logic [FETCH_XLEN-1:0] pc;
    logic                  pred;
  } fetch_entry_t;

  function automatic logic [12:0] imm_b(input logic [31:0] inst);
    return {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [20:0] imm_j(input logic [31:0] inst);
    return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - pointer/count synchronous FIFO with a single-cycle flush
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  // Storage carries no reset; entries are only visible through o_valid.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush && !rst) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC owner, sequential imem fetch, prefetch queue and redirect squash
// Optional static backward-branch/JAL prediction when FETCH_STATIC_PREDICT_EN is defined.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = FETCH_XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic            out_pred_taken
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_inflight;
  logic            r_drop_next;

  logic            w_push;
  logic            w_pop;
  logic            w_pred;
  logic            w_imem_en;
  logic            w_head_valid;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_credit;
  logic [XLEN-1:0] w_pred_target;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  assign w_pop  = w_head_valid && out_ready;
  assign w_push = r_inflight && !r_drop_next && !redirect_valid;

  // Occupancy next cycle must leave room for the response to the request issued now.
  assign w_credit  = {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_pop);
  assign w_imem_en = !rst && !redirect_valid && (w_credit < (CW+1)'(DEPTH));

`ifdef FETCH_STATIC_PREDICT_EN
  logic [6:0]      w_opcode;
  logic [XLEN-1:0] w_pred_sum;
  assign w_opcode   = imem_rdata[6:0];
  assign w_pred     = w_push && ((w_opcode == OP_JAL) ||
                                 ((w_opcode == OP_BRANCH) && imem_rdata[31]));
  assign w_pred_sum = r_req_pc + ((w_opcode == OP_JAL) ? XLEN'($signed(imm_j(imem_rdata)))
                                                       : XLEN'($signed(imm_b(imem_rdata))));
  assign w_pred_target = {w_pred_sum[XLEN-1:2], 2'b00};
`else
  assign w_pred        = 1'b0;
  assign w_pred_target = r_pc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_req_pc    <= RESET_PC;
      r_inflight  <= 1'b0;
      r_drop_next <= 1'b0;
    end else begin
      r_inflight <= w_imem_en;
      if (w_imem_en) r_req_pc <= r_pc;
      if (redirect_valid) begin
        r_pc        <= {redirect_target[XLEN-1:2], 2'b00};
        r_drop_next <= 1'b0;
      end else if (w_pred) begin
        // The sequential request issued alongside the predicted push must be discarded.
        r_pc        <= w_pred_target;
        r_drop_next <= w_imem_en;
      end else begin
        if (w_imem_en)  r_pc <= r_pc + XLEN'(4);
        if (r_inflight) r_drop_next <= 1'b0;
      end
    end
  end

  assign w_push_entry.inst = imem_rdata;
  assign w_push_entry.pc   = r_req_pc;
  assign w_push_entry.pred = w_pred;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_valid (w_head_valid),
    .o_count (w_count)
  );

  assign imem_en        = w_imem_en;
  assign imem_addr      = r_pc;
  assign out_valid      = w_head_valid;
  assign out_inst       = w_head_valid ? w_head.inst : '0;
  assign out_pc         = w_head_valid ? w_head.pc : '0;
  assign out_pc_plus4   = w_head_valid ? (w_head.pc + XLEN'(4)) : '0;
  assign out_pred_taken = w_head_valid && w_head.pred;

endmodule
